// File: rtl/piso_stream_serializer_pkg.sv
// Shared types and elaboration helpers for the parallel-in/serial-out serializer.
// Latency: none (types and constant functions only).
// Backpressure: not applicable.
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } piso_state_t;

    // Number of serial beats needed to drain one parallel word.
    function automatic int beats(input int dw, input int lanes);
        return dw / lanes;
    endfunction

    // Beat counter width; a single-beat word still needs a 1-bit counter.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/piso_stream_serializer_if.sv
// Bundles the word-side handshake and the serial-side outputs of the serializer.
// Latency: none (wiring only).
// Backpressure: s_ready from the slave gates every word transfer from the master.
interface piso_stream_serializer_if #(
    parameter int DATA_WIDTH = 16,
    parameter int LANES      = 1
) ();

    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_valid;
    logic                  s_ready;
    logic                  msb_first;
    logic                  shift_en;
    logic [LANES-1:0]      serial_out;
    logic                  serial_valid;
    logic                  frame_start;
    logic                  frame_last;
    logic                  busy;

    // Producer / environment side.
    modport master (
        output s_data, s_valid, msb_first, shift_en,
        input  s_ready, serial_out, serial_valid, frame_start, frame_last, busy
    );

    // Serializer side.
    modport slave (
        input  s_data, s_valid, msb_first, shift_en,
        output s_ready, serial_out, serial_valid, frame_start, frame_last, busy
    );

endinterface

// File: rtl/piso_stream_serializer_beat_counter.sv
// Modulo-BEATS beat counter with synchronous clear, enable and terminal-count flag.
// Latency: count updates on the edge after en/clr; tc is combinational from the count.
// Backpressure: none; en simply holds the count when low.
module piso_beat_counter
    import piso_pkg::*;
#(
    parameter int BEATS = 16,
    parameter int CNT_W = cnt_width(BEATS)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins, otherwise advance and wrap after the last beat.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
    assign tc  = (cnt_q == LAST);

endmodule

// File: rtl/piso_stream_serializer.sv
// Parallel-in/serial-out shifter: LANES bits per beat, runtime bit order, shift_en pacing.
// Latency: first beat visible right after the load edge; each beat holds until an edge with shift_en=1.
// Backpressure: s_ready is high in IDLE or on the last beat with shift_en=1, allowing zero-gap reloads.
module piso_stream_serializer
    import piso_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int LANES      = 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    piso_stream_serializer_if.slave  bus
);

    localparam int BEATS = beats(DATA_WIDTH, LANES);
    localparam int CNT_W = cnt_width(BEATS);

    // Refuse to build a geometry that cannot be drained in whole beats.
    if ((LANES < 1) || (LANES > DATA_WIDTH) || ((DATA_WIDTH % LANES) != 0)) begin : g_bad_geometry
        $error("piso_stream_serializer: DATA_WIDTH must be a non-zero multiple of LANES");
    end

    piso_state_t           state_q;
    piso_state_t           state_d;
    logic [DATA_WIDTH-1:0] sreg_q;
    logic [DATA_WIDTH-1:0] sreg_d;
    logic                  order_q;
    logic                  order_d;

    logic                  s_ready;
    logic                  cnt_clr;
    logic                  cnt_en;
    logic [CNT_W-1:0]      cnt;
    logic                  cnt_tc;
    logic                  live;

    logic [LANES-1:0]      msb_beat;
    logic [LANES-1:0]      lsb_beat;
    logic [LANES-1:0]      beat;

    piso_beat_counter #(
        .BEATS (BEATS),
        .CNT_W (CNT_W)
    ) u_beat_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (cnt_clr),
        .en      (cnt_en),
        .cnt     (cnt),
        .tc      (cnt_tc)
    );

    // FSM next state, shifter and handshake; the word is captured only when s_ready is high.
    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        order_d = order_q;
        s_ready = 1'b0;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        unique case (state_q)
            IDLE: begin
                s_ready = 1'b1;
                if (bus.s_valid) begin
                    state_d = SHIFT;
                    sreg_d  = bus.s_data;
                    order_d = bus.msb_first;
                    cnt_clr = 1'b1;
                end
            end
            SHIFT: begin
                if (bus.shift_en) begin
                    if (!cnt_tc) begin
                        // Move the next beat into the output end of the register.
                        sreg_d = order_q ? (sreg_q << LANES) : (sreg_q >> LANES);
                        cnt_en = 1'b1;
                    end else begin
                        // Last beat is being consumed: reload straight away or go idle.
                        s_ready = 1'b1;
                        cnt_clr = 1'b1;
                        if (bus.s_valid) begin
                            sreg_d  = bus.s_data;
                            order_d = bus.msb_first;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, shift register and latched bit order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            order_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            order_q <= order_d;
        end
    end

    // MSB-first takes the top lanes as they stand.
    assign msb_beat = sreg_q[DATA_WIDTH-1 -: LANES];

    // LSB-first reverses the bottom lanes so the earliest bit lands on the highest index.
    always_comb begin
        lsb_beat = '0;
        for (int i = 0; i < LANES; i++) begin
            lsb_beat[LANES-1-i] = sreg_q[i];
        end
    end

    // Output beat selection; everything is forced to zero outside a word.
    always_comb begin
        live = (state_q == SHIFT);
        beat = '0;
        if (live) begin
            beat = order_q ? msb_beat : lsb_beat;
        end
    end

    assign bus.s_ready      = s_ready;
    assign bus.serial_out   = beat;
    assign bus.serial_valid = live;
    assign bus.busy         = live;
    assign bus.frame_start  = live && (cnt == '0);
    assign bus.frame_last   = live && cnt_tc;

endmodule

// File: tb/tb_piso_stream_serializer.sv
// Bench for piso_stream_serializer: three geometries (LANES 1, 4, 16) on one clock.
// Latency: inputs are driven at the falling edge, outputs sampled 1 time unit later.
// Backpressure: shift_en pacing and held s_valid exercise both stall and zero-gap reload.
module tb_piso_stream_serializer;

    logic clk;
    logic reset_n;
    int   tests;
    int   fails;
    int   vcycles;

    logic [15:0] wq[$];
    logic        oq[$];

    piso_stream_serializer_if #(.DATA_WIDTH(16), .LANES(1))  if1 ();
    piso_stream_serializer_if #(.DATA_WIDTH(16), .LANES(4))  if4 ();
    piso_stream_serializer_if #(.DATA_WIDTH(16), .LANES(16)) if16 ();

    piso_stream_serializer #(.DATA_WIDTH(16), .LANES(1))  u1  (.clk(clk), .reset_n(reset_n), .bus(if1));
    piso_stream_serializer #(.DATA_WIDTH(16), .LANES(4))  u4  (.clk(clk), .reset_n(reset_n), .bus(if4));
    piso_stream_serializer #(.DATA_WIDTH(16), .LANES(16)) u16 (.clk(clk), .reset_n(reset_n), .bus(if16));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chkb(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: lay the word out as a bit stream in transmit order, then cut it
    // into LANES-wide beats with the earliest bit on the highest lane index.
    function automatic logic [15:0] exp_beat(input logic [15:0] w, input logic msb,
                                             input int lanes, input int k);
        logic [15:0] r;
        int pos;
        r = '0;
        for (int j = 0; j < lanes; j++) begin
            pos = k * lanes + j;
            r[lanes-1-j] = msb ? w[15-pos] : w[pos];
        end
        return r;
    endfunction

    task automatic drv(input int lanes, input logic sv, input logic [15:0] d,
                       input logic msb, input logic se);
        if1.s_valid  = 1'b0; if1.shift_en  = 1'b1;
        if4.s_valid  = 1'b0; if4.shift_en  = 1'b1;
        if16.s_valid = 1'b0; if16.shift_en = 1'b1;
        case (lanes)
            1: begin
                if1.s_valid = sv; if1.s_data = d; if1.msb_first = msb; if1.shift_en = se;
            end
            4: begin
                if4.s_valid = sv; if4.s_data = d; if4.msb_first = msb; if4.shift_en = se;
            end
            default: begin
                if16.s_valid = sv; if16.s_data = d; if16.msb_first = msb; if16.shift_en = se;
            end
        endcase
    endtask

    task automatic smp(input int lanes, output logic rdy, output logic [15:0] so,
                       output logic v, output logic fs, output logic fl, output logic bz);
        case (lanes)
            1: begin
                rdy = if1.s_ready; so = {15'b0, if1.serial_out}; v = if1.serial_valid;
                fs = if1.frame_start; fl = if1.frame_last; bz = if1.busy;
            end
            4: begin
                rdy = if4.s_ready; so = {12'b0, if4.serial_out}; v = if4.serial_valid;
                fs = if4.frame_start; fl = if4.frame_last; bz = if4.busy;
            end
            default: begin
                rdy = if16.s_ready; so = if16.serial_out; v = if16.serial_valid;
                fs = if16.frame_start; fl = if16.frame_last; bz = if16.busy;
            end
        endcase
    endtask

    // Stream every word in wq/oq through one instance and check each cycle.
    task automatic play(input int lanes, input logic pace, input logic b2b);
        int   nb;
        int   k;
        logic se;
        logic more;
        logic rdy, v, fs, fl, bz;
        logic [15:0] so;
        nb = 16 / lanes;
        se = 1'b1;
        vcycles = 0;
        for (int i = 0; i < wq.size(); i++) begin
            if (i == 0 || !b2b) begin
                @(negedge clk);
                drv(lanes, 1'b1, wq[i], oq[i], se);
                #1 smp(lanes, rdy, so, v, fs, fl, bz);
                chkb("idle_ready", rdy, 1'b1);
                chkb("idle_valid", v, 1'b0);
                chkw("idle_out", so, 16'h0000);
                se = pace ? ~se : 1'b1;
            end
            k = 0;
            while (k < nb) begin
                more = b2b && (i + 1 < wq.size());
                @(negedge clk);
                drv(lanes, more, more ? wq[i+1] : 16'($urandom),
                    more ? oq[i+1] : 1'($urandom), se);
                #1 smp(lanes, rdy, so, v, fs, fl, bz);
                if (v) vcycles++;
                chkw("beat_data", so, exp_beat(wq[i], oq[i], lanes, k));
                chkb("beat_valid", v, 1'b1);
                chkb("beat_busy", bz, 1'b1);
                chkb("frame_start", fs, k == 0);
                chkb("frame_last", fl, k == nb - 1);
                chkb("beat_ready", rdy, (k == nb - 1) && se);
                if (se) k++;
                se = pace ? ~se : 1'b1;
            end
        end
        @(negedge clk);
        drv(lanes, 1'b0, 16'($urandom), 1'($urandom), 1'b1);
        #1 smp(lanes, rdy, so, v, fs, fl, bz);
        chkb("end_valid", v, 1'b0);
        chkb("end_ready", rdy, 1'b1);
        chkw("end_out", so, 16'h0000);
    endtask

    initial begin
        logic rdy, v, fs, fl, bz;
        logic [15:0] so;
        int n;
        int lanes;
        tests = 0;
        fails = 0;
        reset_n = 1'b0;
        drv(1, 1'b0, 16'h0000, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        #1 smp(1, rdy, so, v, fs, fl, bz);
        chkb("rst_valid", v, 1'b0);
        chkw("rst_out", so, 16'h0000);
        chkb("rst_fstart", fs, 1'b0);
        chkb("rst_flast", fl, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        #1 smp(1, rdy, so, v, fs, fl, bz);
        chkb("rel_ready", rdy, 1'b1);

        // Single word MSB first.
        wq = '{16'hA5C3}; oq = '{1'b1};
        play(1, 1'b0, 1'b0);
        // LSB first, and nibble lanes in both orders.
        wq = '{16'h0001}; oq = '{1'b0};
        play(1, 1'b0, 1'b0);
        wq = '{16'h1234, 16'h1234}; oq = '{1'b1, 1'b0};
        play(4, 1'b0, 1'b0);
        chkw("nib_lsb_first", exp_beat(16'h1234, 1'b0, 4, 0), 16'h0002);
        // Back-to-back with s_valid held.
        wq = '{16'hFFFF, 16'h0000}; oq = '{1'b1, 1'b1};
        play(1, 1'b0, 1'b1);
        chkw("b2b_cycles", 16'(vcycles), 16'd32);
        // Half-rate pacing.
        wq = '{16'hA5C3}; oq = '{1'b1};
        play(1, 1'b1, 1'b0);
        chkw("pace_cycles", 16'(vcycles), 16'd32);

        // Asynchronous reset in the middle of beat 7.
        @(negedge clk);
        drv(1, 1'b1, 16'hA5C3, 1'b1, 1'b1);
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            drv(1, 1'b0, 16'($urandom), 1'b1, 1'b1);
            #1 smp(1, rdy, so, v, fs, fl, bz);
            chkw("pre_rst_beat", so, exp_beat(16'hA5C3, 1'b1, 1, k));
        end
        #2 reset_n = 1'b0;
        #1 smp(1, rdy, so, v, fs, fl, bz);
        chkb("arst_valid", v, 1'b0);
        chkb("arst_busy", bz, 1'b0);
        chkw("arst_out", so, 16'h0000);
        chkb("arst_fstart", fs, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        #1 smp(1, rdy, so, v, fs, fl, bz);
        chkb("arst_rel_ready", rdy, 1'b1);
        chkb("arst_rel_valid", v, 1'b0);
        wq = '{16'h8000}; oq = '{1'b1};
        play(1, 1'b0, 1'b0);

        // Full-width lanes: one beat per word, reload every cycle.
        wq = '{16'hBEEF, 16'h1234, 16'hC0DE}; oq = '{1'b1, 1'b0, 1'b1};
        play(16, 1'b0, 1'b1);
        chkw("wide_cycles", 16'(vcycles), 16'd3);
        wq = '{16'hBEEF}; oq = '{1'b0};
        play(16, 1'b0, 1'b0);

        // Randomized words, orders, geometries, pacing and streaming.
        for (int r = 0; r < 40; r++) begin
            wq.delete();
            oq.delete();
            n = $urandom_range(1, 3);
            for (int i = 0; i < n; i++) begin
                wq.push_back(16'($urandom));
                oq.push_back(1'($urandom));
            end
            case ($urandom_range(0, 2))
                0: lanes = 1;
                1: lanes = 4;
                default: lanes = 16;
            endcase
            play(lanes, 1'($urandom), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
